id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage LA32R pipeline, directly downstream of the fetch stage. It latches `{inst, pc}` from fetch and decodes a fixed integer subset. It reads the register file through forwarding from EX/MEM/WB, stalls on load-use, resolves branches, and returns the redirect bus to fetch. The decoded bundle goes to EX under the valid/allowin handshake.

## Interface
Parameters: none.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `fs_to_ds_valid` in 1: fetch has an instruction.
- `fs_to_ds_bus` in 64: `{inst[63:32], pc[31:0]}`.
- `ds_allowin` out 1: ID accepts a new instruction this cycle.
- `br_bus` out 34: `{br_taken_cancel, br_taken, br_target[31:0]}`.
- `es_allowin` in 1: EX accepts.
- `ds_to_es_valid` out 1: bundle valid.
- `ds_to_es_bus` out 148: `{alu_op[11:0], src1[31:0], src2[31:0], rkd_value[31:0], dest[4:0], gr_we, mem_we, res_from_mem, pc[31:0]}`, MSB first.
- `es_fwd_bus` in 39: `{valid, is_load, dest[4:0], value[31:0]}`.
- `ms_fwd_bus` in 38: `{valid, dest[4:0], value[31:0]}`.
- `ws_to_rf_bus` in 38: `{we, waddr[4:0], wdata[31:0]}`. Writes the RF and is also the lowest-priority forward source.

## Operation
- Supported: `add.w sub.w slt sltu and or xor nor slli.w srli.w srai.w addi.w lu12i.w ld.w st.w jirl b bl beq bne`. Any other encoding is decoded as a no-op: `gr_we=0`, `mem_we=0`, no branch.
- Register sources:
  - rj = `inst[9:5]`.
  - Second source is rk = `inst[14:10]`, except for `beq/bne/st.w`, which use rd = `inst[4:0]`.
  - dest = rd, or 1 for `bl`. dest is forced to 0 when `gr_we=0`.
- Operand read:
  - Register 0 reads 0 and is never forwarded.
  - Otherwise the value comes from the first match in priority order: EX (valid, non-load), MEM, WB (we), then the RF read.
- Load-use stall: `ds_ready_go = 0` when EX is valid with `is_load` and its dest matches a used nonzero source.
- Immediates:
  - si12: sign-extended.
  - ui5: zero-extended.
  - `lu12i.w`: `{si20, 12'b0}`.
  - Branch offsets are sign-extended `{offs,2'b0}`, with offs16 = `inst[25:10]` and offs26 = `{inst[9:0], inst[25:10]}`.
- Link instructions (`bl`, `jirl`): src1 = pc, src2 = 4, ALU add.
- Branch target:
  - `b/bl/beq/bne`: pc + offset.
  - `jirl`: rj + offset.
  - All adds are 32-bit with wrap-around.
- `br_taken = ds_valid & ds_ready_go & es_allowin & (b | bl | jirl | (beq & rj==rd) | (bne & rj!=rd))`. `br_taken_cancel = br_taken`.
- Wrong-path drop: when `br_taken` is high, fetch still hands over its sequential instruction on the same edge. ID loads it as invalid (`ds_valid <= fs_to_ds_valid & ~br_taken`).
- Handshake:
  - `ds_allowin = ~ds_valid | (ds_ready_go & es_allowin)`.
  - `ds_to_es_valid = ds_valid & ds_ready_go`.
  - The instruction register loads only when `ds_allowin` is high.
- Reset: `ds_valid = 0`, so `ds_to_es_valid = 0` and `br_bus = 0`. The RF is not cleared. Reset asserted mid-stall discards the held instruction.

## Timing
- Decode, forwarding and branch resolution are combinational from the ID register. Latency is one cycle from the fetch handshake to `ds_to_es_valid`.
- A taken branch gives a one-bubble penalty. The target is fetched in the cycle after `br_taken`.
- RF write happens at the clock edge. A same-cycle read gets the new value via the WB forward path.
- Load-use costs one stall cycle. On the following cycle the load is in MEM and is forwarded.
- If `es_allowin=0` while a branch is taken in ID, `br_taken` stays 0 until EX accepts. No redirect is issued twice.

## Structure
- Shared package: bus widths (34/64/148/39/38), the `alu_op` one-hot bit indices (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui), and the reset PC.
- Sub-module `regfile`: 32x32, two async read ports, one sync write port. Writes to r0 are ignored.

## Test plan
- `addi.w r1,r0,5` then `add.w r2,r1,r1` back-to-back -> EX forward gives src1 = src2 = 5, no stall.
- `ld.w r3,r0,0` then `add.w r4,r3,r0` -> `ds_to_es_valid` low for 1 cycle, then valid with the value forwarded from MEM.
- `beq r0,r0,+8` at pc 0x1C000000 -> `br_bus = {1,1,0x1C000008}` for one cycle, and the instruction at 0x1C000004 never reaches EX.
- `bne` with equal operands -> `br_taken=0`, sequential flow continues.
- `jirl r1,r5,4` with r5=0x1C000100 -> target 0x1C000104, dest 1, src1 = pc, src2 = 4.
- Hold `es_allowin=0` for 3 cycles with a valid add in ID -> `ds_allowin=0` and the bus is stable. Assert `reset` during the hold -> `ds_to_es_valid=0` on the next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared definitions for the LA32R decode stage: bus widths, ALU op bit indices, reset PC.
package id_stage_pkg;

    localparam int BR_BUS_W       = 34;
    localparam int FS_TO_DS_BUS_W = 64;
    localparam int DS_TO_ES_BUS_W = 148;
    localparam int ES_FWD_BUS_W   = 39;
    localparam int MS_FWD_BUS_W   = 38;
    localparam int WS_TO_RF_BUS_W = 38;

    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port; r0 reads zero.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] rf [32];

    always_ff @(posedge clk) begin
        if (we && waddr != '0)
            rf[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];

endmodule

// File: rtl/id_stage.sv
// LA32R decode stage: instruction latch, decode, operand forwarding, load-use stall, branch resolution.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
    output logic                      ds_allowin,
    output logic [BR_BUS_W-1:0]       br_bus,
    input  logic                      es_allowin,
    output logic                      ds_to_es_valid,
    output logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus,
    input  logic [ES_FWD_BUS_W-1:0]   es_fwd_bus,
    input  logic [MS_FWD_BUS_W-1:0]   ms_fwd_bus,
    input  logic [WS_TO_RF_BUS_W-1:0] ws_to_rf_bus
);

    logic                      ds_valid;
    logic                      ds_ready_go;
    logic                      br_taken;
    logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus_r;

    always_ff @(posedge clk) begin
        if (reset)
            ds_valid <= 1'b0;
        else if (ds_allowin)
            ds_valid <= fs_to_ds_valid & ~br_taken;
        if (ds_allowin)
            fs_to_ds_bus_r <= fs_to_ds_bus;
    end

    logic [31:0] inst, pc;
    assign {inst, pc} = fs_to_ds_bus_r;

    logic [4:0]  rd, rj, rk, r2;
    logic [11:0] si12;
    logic [4:0]  ui5;
    logic [19:0] si20;
    logic [15:0] offs16;
    logic [25:0] offs26;
    assign rd     = inst[4:0];
    assign rj     = inst[9:5];
    assign rk     = inst[14:10];
    assign si12   = inst[21:10];
    assign ui5    = inst[14:10];
    assign si20   = inst[24:5];
    assign offs16 = inst[25:10];
    assign offs26 = {inst[9:0], inst[25:10]};

    logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
    logic i_slli, i_srli, i_srai, i_addi, i_ld, i_st, i_lu12i;
    logic i_jirl, i_b, i_bl, i_beq, i_bne;
    assign i_add   = inst[31:15] == 17'h00020;
    assign i_sub   = inst[31:15] == 17'h00022;
    assign i_slt   = inst[31:15] == 17'h00024;
    assign i_sltu  = inst[31:15] == 17'h00025;
    assign i_nor   = inst[31:15] == 17'h00028;
    assign i_and   = inst[31:15] == 17'h00029;
    assign i_or    = inst[31:15] == 17'h0002a;
    assign i_xor   = inst[31:15] == 17'h0002b;
    assign i_slli  = inst[31:15] == 17'h00081;
    assign i_srli  = inst[31:15] == 17'h00089;
    assign i_srai  = inst[31:15] == 17'h00091;
    assign i_addi  = inst[31:22] == 10'h00a;
    assign i_ld    = inst[31:22] == 10'h0a2;
    assign i_st    = inst[31:22] == 10'h0a6;
    assign i_lu12i = inst[31:25] == 7'h0a;
    assign i_jirl  = inst[31:26] == 6'h13;
    assign i_b     = inst[31:26] == 6'h14;
    assign i_bl    = inst[31:26] == 6'h15;
    assign i_beq   = inst[31:26] == 6'h16;
    assign i_bne   = inst[31:26] == 6'h17;

    logic is_3r, is_shi, is_link, uses_rj, uses_r2, gr_we, mem_we, res_from_mem;
    assign is_3r   = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
    assign is_shi  = i_slli | i_srli | i_srai;
    assign is_link = i_jirl | i_bl;
    assign uses_rj = is_3r | is_shi | i_addi | i_ld | i_st | i_jirl | i_beq | i_bne;
    assign uses_r2 = is_3r | i_beq | i_bne | i_st;
    assign r2      = (i_beq | i_bne | i_st) ? rd : rk;
    assign gr_we   = is_3r | is_shi | i_addi | i_ld | i_lu12i | is_link;
    assign mem_we  = i_st;
    assign res_from_mem = i_ld;

    logic [4:0] dest;
    assign dest = !gr_we ? 5'd0 : (i_bl ? 5'd1 : rd);

    logic [ALU_OP_W-1:0] alu_op;
    always_comb begin
        alu_op           = '0;
        alu_op[ALU_ADD]  = i_add | i_addi | i_ld | i_st | is_link;
        alu_op[ALU_SUB]  = i_sub;
        alu_op[ALU_SLT]  = i_slt;
        alu_op[ALU_SLTU] = i_sltu;
        alu_op[ALU_AND]  = i_and;
        alu_op[ALU_NOR]  = i_nor;
        alu_op[ALU_OR]   = i_or;
        alu_op[ALU_XOR]  = i_xor;
        alu_op[ALU_SLL]  = i_slli;
        alu_op[ALU_SRL]  = i_srli;
        alu_op[ALU_SRA]  = i_srai;
        alu_op[ALU_LUI]  = i_lu12i;
    end

    logic        es_valid, es_is_load, ms_valid, ws_we;
    logic [4:0]  es_dest, ms_dest, ws_waddr;
    logic [31:0] es_value, ms_value, ws_wdata;
    assign {es_valid, es_is_load, es_dest, es_value} = es_fwd_bus;
    assign {ms_valid, ms_dest, ms_value}             = ms_fwd_bus;
    assign {ws_we, ws_waddr, ws_wdata}               = ws_to_rf_bus;

    logic [31:0] rf_rdata1, rf_rdata2;
    regfile u_regfile (
        .clk    (clk),
        .raddr1 (rj),
        .rdata1 (rf_rdata1),
        .raddr2 (r2),
        .rdata2 (rf_rdata2),
        .we     (ws_we),
        .waddr  (ws_waddr),
        .wdata  (ws_wdata)
    );

    // Youngest producer wins; a load in EX has no value yet and is handled by the stall instead.
    function automatic logic [31:0] fwd_read(input logic [4:0] r, input logic [31:0] rf_val);
        if (r == '0)                                      return '0;
        if (es_valid && !es_is_load && es_dest == r)      return es_value;
        if (ms_valid && ms_dest == r)                     return ms_value;
        if (ws_we && ws_waddr == r)                       return ws_wdata;
        return rf_val;
    endfunction

    logic [31:0] rj_value, rkd_value;
    assign rj_value  = fwd_read(rj, rf_rdata1);
    assign rkd_value = fwd_read(r2, rf_rdata2);

    logic load_use;
    assign load_use = es_valid & es_is_load & (es_dest != '0) &
                      ((uses_rj & (es_dest == rj)) | (uses_r2 & (es_dest == r2)));
    assign ds_ready_go = ~load_use;

    logic [31:0] src1, src2;
    assign src1 = is_link ? pc : rj_value;
    always_comb begin
        src2 = rkd_value;
        if (is_link)                   src2 = 32'd4;
        else if (i_addi | i_ld | i_st) src2 = {{20{si12[11]}}, si12};
        else if (is_shi)               src2 = {27'd0, ui5};
        else if (i_lu12i)              src2 = {si20, 12'd0};
    end

    logic [31:0] offs16_ext, offs26_ext, br_target;
    logic        br_cond;
    assign offs16_ext = {{14{offs16[15]}}, offs16, 2'b00};
    assign offs26_ext = {{4{offs26[25]}}, offs26, 2'b00};
    assign br_target  = i_jirl ? rj_value + offs16_ext
                               : pc + ((i_b | i_bl) ? offs26_ext : offs16_ext);
    assign br_cond    = i_b | i_bl | i_jirl | (i_beq & (rj_value == rkd_value))
                                            | (i_bne & (rj_value != rkd_value));
    assign br_taken   = ds_valid & ds_ready_go & es_allowin & br_cond;
    assign br_bus     = {br_taken, br_taken, br_taken ? br_target : 32'd0};

    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go;
    assign ds_to_es_bus   = {alu_op, src1, src2, rkd_value, dest, gr_we, mem_we, res_from_mem, pc};

endmodule
